// File: rtl/uart_mux_tx_rs485.sv
// RS485 burst transmitter: walks an external N-to-1 mux with sel, frames each word as
// async serial, and sequences the transceiver direction pins with guard delays.
module uart_mux_tx_rs485 #(
   parameter int NUM_BYTES    = 8,
   parameter int SEL_W        = 3,
   parameter int DATA_W       = 8,
   parameter int CLKS_PER_BIT = 1,
   parameter int GUARD        = 15,
   parameter int PARITY       = 0,
   parameter int STOP_BITS    = 1,
   parameter int MSB_FIRST    = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              rq,
   input  logic [DATA_W-1:0] data,
   output logic              tx,
   output logic              dir_tx,
   output logic              dir_rx,
   output logic [SEL_W-1:0]  sel,
   output logic              busy,
   output logic              done
);

   localparam int SH_W     = DATA_W + 3;
   localparam int BI_W     = $clog2(DATA_W + 5);
   localparam int LAST_BIT = DATA_W + ((PARITY != 0) ? 1 : 0) + STOP_BITS;

   typedef enum logic [2:0] {IDLE, DIR_ON, SEND, DIR_OFF, REARM} state_t;

   state_t            state;
   logic              rq_m, rq_s;
   logic [7:0]        gcnt;
   logic [15:0]       bcnt;
   logic [BI_W-1:0]   bidx;
   logic [SEL_W:0]    widx;
   logic [SH_W-1:0]   shreg;
   logic [DATA_W-1:0] ordered;
   logic              par_bit;
   logic [SH_W-1:0]   load_val;
   logic [SEL_W:0]    sel_inc;
   logic [SEL_W-1:0]  sel_next;

   genvar gi;
   generate
      for (gi = 0; gi < DATA_W; gi++) begin : g_order
         assign ordered[gi] = (MSB_FIRST != 0) ? data[DATA_W-1-gi] : data[gi];
      end
   endgenerate

   // Shift register holds everything after the start bit, LSB sent first; spare top bits are stop-level ones.
   always_comb begin
      par_bit = (PARITY == 2) ? ~(^data) : ^data;
      if (PARITY != 0) load_val = {2'b11, par_bit, ordered};
      else             load_val = {3'b111, ordered};
      sel_inc  = {1'b0, sel} + 1'b1;
      sel_next = (sel_inc == (SEL_W+1)'(NUM_BYTES)) ? '0 : sel_inc[SEL_W-1:0];
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state  <= IDLE;
         rq_m   <= 1'b0;
         rq_s   <= 1'b0;
         gcnt   <= '0;
         bcnt   <= '0;
         bidx   <= '0;
         widx   <= '0;
         shreg  <= '1;
         tx     <= 1'b1;
         dir_tx <= 1'b0;
         dir_rx <= 1'b0;
         sel    <= '0;
         busy   <= 1'b0;
         done   <= 1'b0;
      end else begin
         rq_m <= rq;
         rq_s <= rq_m;
         done <= 1'b0;
         case (state)
            IDLE: if (rq_s) begin
               state  <= DIR_ON;
               dir_rx <= 1'b1;
               busy   <= 1'b1;
               gcnt   <= '0;
            end
            // dir_tx itself marks which of the two guard intervals is running.
            DIR_ON: if (gcnt == 8'(GUARD - 1)) begin
               gcnt <= '0;
               if (!dir_tx) dir_tx <= 1'b1;
               else begin
                  state <= SEND;
                  tx    <= 1'b0;
                  shreg <= load_val;
                  sel   <= sel_next;
                  widx  <= '0;
                  bcnt  <= '0;
                  bidx  <= '0;
               end
            end else gcnt <= gcnt + 8'd1;
            SEND: if (bcnt == 16'(CLKS_PER_BIT - 1)) begin
               bcnt <= '0;
               if (bidx == BI_W'(LAST_BIT)) begin
                  bidx <= '0;
                  if (widx == (SEL_W+1)'(NUM_BYTES - 1)) begin
                     state <= DIR_OFF;
                     tx    <= 1'b1;
                     gcnt  <= '0;
                  end else begin
                     tx    <= 1'b0;
                     shreg <= load_val;
                     sel   <= sel_next;
                     widx  <= widx + 1'b1;
                  end
               end else begin
                  bidx  <= bidx + 1'b1;
                  tx    <= shreg[0];
                  shreg <= {1'b1, shreg[SH_W-1:1]};
               end
            end else bcnt <= bcnt + 16'd1;
            DIR_OFF: if (gcnt == 8'(GUARD - 1)) begin
               gcnt <= '0;
               if (dir_tx) dir_tx <= 1'b0;
               else begin
                  dir_rx <= 1'b0;
                  done   <= 1'b1;
                  busy   <= 1'b0;
                  state  <= REARM;
               end
            end else gcnt <= gcnt + 8'd1;
            REARM: if (!rq_s) state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_uart_mux_tx_rs485.sv
// Bench for uart_mux_tx_rs485: three configurations, cycle-by-cycle comparison of all
// outputs against a timeline computed from frame arithmetic.
module tb_uart_mux_tx_rs485;

   logic clk = 1'b0;
   logic reset = 1'b0;
   always #5 clk = ~clk;

   logic rq0 = 1'b0, rq1 = 1'b0, rq2 = 1'b0;
   logic [7:0] data0, data2;
   logic [6:0] data1;
   logic tx0, tx1, tx2, dtx0, dtx1, dtx2, drx0, drx1, drx2;
   logic busy0, busy1, busy2, done0, done1, done2;
   logic [2:0] sel0;
   logic [1:0] sel1;
   logic [0:0] sel2;
   logic [7:0] mem0[8];
   logic [6:0] mem1[4];
   logic [7:0] mem2[2];

   assign data0 = mem0[sel0];
   assign data1 = mem1[sel1];
   assign data2 = mem2[sel2];

   // per-instance configuration: nb, dw, cpb, guard, parity, stop, msb_first
   int c_nb[3]  = '{8, 4, 2};
   int c_dw[3]  = '{8, 7, 8};
   int c_cpb[3] = '{1, 4, 2};
   int c_g[3]   = '{15, 3, 1};
   int c_par[3] = '{0, 2, 1};
   int c_stp[3] = '{1, 2, 1};
   int c_msb[3] = '{0, 1, 0};

   int checks = 0;
   int errors = 0;

   uart_mux_tx_rs485 u0 (
      .clk(clk), .reset(reset), .rq(rq0), .data(data0), .tx(tx0), .dir_tx(dtx0),
      .dir_rx(drx0), .sel(sel0), .busy(busy0), .done(done0));

   uart_mux_tx_rs485 #(.NUM_BYTES(4), .SEL_W(2), .DATA_W(7), .CLKS_PER_BIT(4), .GUARD(3),
                       .PARITY(2), .STOP_BITS(2), .MSB_FIRST(1)) u1 (
      .clk(clk), .reset(reset), .rq(rq1), .data(data1), .tx(tx1), .dir_tx(dtx1),
      .dir_rx(drx1), .sel(sel1), .busy(busy1), .done(done1));

   uart_mux_tx_rs485 #(.NUM_BYTES(2), .SEL_W(1), .DATA_W(8), .CLKS_PER_BIT(2), .GUARD(1),
                       .PARITY(1), .STOP_BITS(1), .MSB_FIRST(0)) u2 (
      .clk(clk), .reset(reset), .rq(rq2), .data(data2), .tx(tx2), .dir_tx(dtx2),
      .dir_rx(drx2), .sel(sel2), .busy(busy2), .done(done2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d", tag, got, exp);
      end
   endtask

   function automatic int word_of(input int idx, input int k);
      case (idx)
         0:       return int'(mem0[k]);
         1:       return int'(mem1[k]);
         default: return int'(mem2[k]);
      endcase
   endfunction

   // Value of bit j of the frame carrying word k.
   function automatic int fbit(input int idx, input int k, input int j);
      int d, dw, ones;
      d  = word_of(idx, k);
      dw = c_dw[idx];
      if (j == 0) return 0;
      if (j <= dw) return (c_msb[idx] != 0) ? (d >> (dw - j)) & 1 : (d >> (j - 1)) & 1;
      ones = $countones(d);
      if (j == dw + 1 && c_par[idx] == 1) return ones % 2;
      if (j == dw + 1 && c_par[idx] == 2) return 1 - (ones % 2);
      return 1;
   endfunction

   task automatic set_rq(input int idx, input logic v);
      case (idx)
         0:       rq0 = v;
         1:       rq1 = v;
         default: rq2 = v;
      endcase
   endtask

   task automatic observe(input int idx, output int t, output int dt, output int dr,
                          output int bz, output int dn, output int s);
      case (idx)
         0:       begin t = tx0; dt = dtx0; dr = drx0; bz = busy0; dn = done0; s = int'(sel0); end
         1:       begin t = tx1; dt = dtx1; dr = drx1; bz = busy1; dn = done1; s = int'(sel1); end
         default: begin t = tx2; dt = dtx2; dr = drx2; bz = busy2; dn = done2; s = int'(sel2); end
      endcase
   endtask

   task automatic fill(input int idx);
      case (idx)
         0:       foreach (mem0[k]) mem0[k] = 8'($urandom);
         1:       foreach (mem1[k]) mem1[k] = 7'($urandom);
         default: foreach (mem2[k]) mem2[k] = 8'($urandom);
      endcase
   endtask

   // Called at a negedge on which the request (or reset release with rq high) has just happened.
   task automatic run_burst(input int idx, input int hold, input int drop_at);
      int f, b, t_send, last, g, o, w;
      int e_tx, e_dt, e_dr, e_dn, e_sel;
      int t, dt, dr, bz, dn, s;
      g      = c_g[idx];
      f      = c_cpb[idx] * (1 + c_dw[idx] + ((c_par[idx] != 0) ? 1 : 0) + c_stp[idx]);
      b      = c_nb[idx] * f;
      t_send = 3 + 2 * g;
      last   = 3 + 4 * g + b;
      for (int n = 1; n <= last + hold; n++) begin
         @(negedge clk);
         e_dr  = (n >= 3 && n < last) ? 1 : 0;
         e_dt  = (n >= 3 + g && n < 3 + 3 * g + b) ? 1 : 0;
         e_dn  = (n == last) ? 1 : 0;
         e_tx  = 1;
         e_sel = 0;
         if (n >= t_send && n < t_send + b) begin
            o     = n - t_send;
            w     = o / f;
            e_tx  = fbit(idx, w, (o % f) / c_cpb[idx]);
            e_sel = (w + 1) % c_nb[idx];
         end
         observe(idx, t, dt, dr, bz, dn, s);
         check($sformatf("i%0d n%0d tx", idx, n), t, e_tx);
         check($sformatf("i%0d n%0d dir_tx", idx, n), dt, e_dt);
         check($sformatf("i%0d n%0d dir_rx", idx, n), dr, e_dr);
         check($sformatf("i%0d n%0d busy", idx, n), bz, e_dr);
         check($sformatf("i%0d n%0d done", idx, n), dn, e_dn);
         check($sformatf("i%0d n%0d sel", idx, n), s, e_sel);
         if (n == drop_at) set_rq(idx, 1'b0);
      end
      $display("burst inst=%0d frame=%0d clks burst=%0d clks checks=%0d errors=%0d",
               idx, f, b, checks, errors);
   endtask

   task automatic rearm(input int idx);
      set_rq(idx, 1'b0);
      repeat (5) @(negedge clk);
   endtask

   task automatic check_reset_vals(input string tag);
      for (int i = 0; i < 3; i++) begin
         int t, dt, dr, bz, dn, s;
         observe(i, t, dt, dr, bz, dn, s);
         check($sformatf("%s i%0d tx", tag, i), t, 1);
         check($sformatf("%s i%0d dir", tag, i), {dt[0], dr[0]}, 0);
         check($sformatf("%s i%0d busy_done", tag, i), {bz[0], dn[0]}, 0);
         check($sformatf("%s i%0d sel", tag, i), s, 0);
      end
   endtask

   initial begin
      foreach (mem0[k]) mem0[k] = 8'hA0 + 8'(k);
      foreach (mem1[k]) mem1[k] = 7'h41;
      foreach (mem2[k]) mem2[k] = 8'h07;
      repeat (3) @(negedge clk);
      check_reset_vals("reset");
      reset = 1'b1;

      // Defaults with A0+sel; rq held for several burst lengths must give one burst only.
      @(negedge clk); rq0 = 1'b1;
      run_burst(0, 3 * 143, 0);
      rearm(0);
      fill(0);
      @(negedge clk); rq0 = 1'b1;
      run_burst(0, 4, 20);
      rearm(0);

      // Even parity: 07 gives parity 1, 00 gives parity 0.
      @(negedge clk); rq2 = 1'b1;
      run_burst(2, 4, 0);
      rearm(2);
      mem2[0] = 8'h00;
      @(negedge clk); rq2 = 1'b1;
      run_burst(2, 4, 0);
      rearm(2);

      // MSB-first 7-bit words, odd parity, 2 stop bits, 4 clks per bit.
      mem1[1] = 7'h07;
      mem1[2] = 7'h00;
      @(negedge clk); rq1 = 1'b1;
      run_burst(1, 4, 0);
      rearm(1);

      for (int r = 0; r < 3; r++) begin
         for (int i = 0; i < 3; i++) begin
            fill(i);
            @(negedge clk); set_rq(i, 1'b1);
            run_burst(i, 3, 0);
            rearm(i);
         end
      end

      // Abort during word 3, bit 4, then a fresh burst with rq still high.
      foreach (mem0[k]) mem0[k] = 8'($urandom);
      @(negedge clk); rq0 = 1'b1;
      repeat (67) @(negedge clk);
      check("pre-abort tx", tx0, fbit(0, 3, 4));
      check("pre-abort sel", sel0, 4);
      reset = 1'b0;
      #1;
      check_reset_vals("abort");
      @(negedge clk);
      check_reset_vals("abort hold");
      reset = 1'b1;
      run_burst(0, 4, 0);
      rearm(0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/uart_mux_tx_rs485.md
Name: uart_mux_tx_rs485

Overview:
Parametrised RS485 burst transmitter. On a request from another clock domain, it reads NUM_BYTES words through an external N-to-1 multiplexer that it drives with its own select output. It sends each word as an async serial frame, with configurable width, parity, stop bits, bit order and clocks-per-bit. It sequences the transceiver DIR_TX/DIR_RX pins with guard delays around the burst, and sits between telemetry/data muxes and the RS485 line driver.

Parameters:
NUM_BYTES, 8, words per burst (2..256)
SEL_W, 3, select width; must equal clog2(NUM_BYTES)
DATA_W, 8, bits per word (5..16)
CLKS_PER_BIT, 1, clk cycles per serial bit (1..65535)
GUARD, 15, clk cycles between DIR edges and line activity (1..255)
PARITY, 0, 0 = none, 1 = even, 2 = odd
STOP_BITS, 1, 1 or 2
MSB_FIRST, 0, 0 = data[0] sent first, 1 = data[DATA_W-1] sent first

Ports:
clk  in  1  bit/oversample clock
reset  in  1  asynchronous active-low reset
rq  in  1  transfer request, asynchronous to clk, level
data  in  DATA_W  word selected by sel (external mux output)
tx  out  1  serial line, idle high
dir_tx  out  1  RS485 driver enable
dir_rx  out  1  RS485 receiver disable (high during burst)
sel  out  SEL_W  mux select
busy  out  1  high from DIR_ON entry until REARM entry
done  out  1  one-cycle pulse at burst completion

Behaviour:
- Reset (async, reset=0): tx=1, dir_tx=0, dir_rx=0, sel=0, busy=0, done=0, state IDLE, all counters 0, synchroniser cleared.
- rq passes through a 2-FF synchroniser (rq_s); no other use of raw rq.
- States: IDLE, DIR_ON, SEND, DIR_OFF, REARM.
- IDLE: when rq_s=1, go to DIR_ON; dir_rx<=1 and busy<=1 on that edge. sel=0 throughout.
- DIR_ON: guard counter runs. dir_tx<=1 exactly GUARD clocks after dir_rx rose. Enter SEND GUARD clocks after dir_tx rose.
- SEND frame per word:
  - Start bit (0).
  - DATA_W data bits in MSB_FIRST order.
  - Parity bit if PARITY!=0: even makes the total count of ones in data+parity even; odd makes it odd.
  - STOP_BITS bits of 1.
  - Each bit is held exactly CLKS_PER_BIT clocks.
  - Frame length F = CLKS_PER_BIT*(1+DATA_W+(PARITY!=0)+STOP_BITS).
- Word k (0..NUM_BYTES-1) is latched into the shift register on the first clock of its start bit, from data while sel=k. On that same edge sel<=k+1, wrapping to 0 after the last word. The external mux therefore has a full frame to settle.
- Frames are back-to-back: the next start bit follows the last stop bit with no extra idle cycle. Burst length is NUM_BYTES*F clocks.
- After the last stop bit of word NUM_BYTES-1, enter DIR_OFF with tx=1. sel is 0 at this point.
- DIR_OFF: dir_tx<=0 GUARD clocks after entry. dir_rx<=0 GUARD clocks after dir_tx falls. On that same edge: done=1 for one cycle, busy<=0, go to REARM.
- REARM: wait for rq_s=0, then go to IDLE. A held rq never retriggers; a new burst needs an rq low-then-high.
- rq deasserted during DIR_ON/SEND/DIR_OFF is ignored; the burst always completes.
- Async reset mid-burst aborts immediately to reset values. The line returns to idle-high and DIR drops in the same cycle; no partial-frame completion.
- Counters: bit-time counter is ≥16 bits. Bit index is sized for DATA_W+4. Guard counter is 8 bits. Word index is SEL_W+1 bits so NUM_BYTES = 2^SEL_W terminates correctly.
- tx, dir_tx, dir_rx, sel are registered outputs (glitch-free).

Test Plan:
- Defaults, data = 8'hA0+sel, pulse rq: dir_rx rises 3 clks after rq, dir_tx +15, first start bit +15. Eight 10-clk frames carry A0..A7 LSB first, sel sequence 1..7,0. dir_tx falls 15 clks after the last stop bit, dir_rx and a single done pulse 15 later.
- PARITY=1, data=8'h07: parity bit 1. PARITY=2, data=8'h07: parity bit 0. Check both with PARITY=1, data=8'h00 → parity bit 0.
- CLKS_PER_BIT=4, STOP_BITS=2, DATA_W=7, MSB_FIRST=1, data=7'h41: each bit lasts 4 clks, bit order 1,0,0,0,0,0,1, frame = 40 clks.
- rq held high for 3 bursts' duration: exactly one burst and one done. Drop rq, raise again: a second burst.
- reset asserted mid-frame (word 3, bit 4): tx=1, dir_tx=dir_rx=0, sel=0 within the same cycle. After release with rq still high, a full fresh burst starts from word 0.
- NUM_BYTES=4, SEL_W=2: exactly 4 frames, sel wraps 1,2,3,0, burst ends correctly.
